// File: rtl/dpm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dpm_pkg
// Description : Definitions shared by the producer and consumer DPM timing
//               models. Contains the ceiling-divide helper, the LFSR seed,
//               taps and step function, the FSM state encoding and the
//               TileGroup index type.
// Revision    : 1.0 - initial release
// ============================================================================
package dpm_pkg;

    localparam logic [7:0] LFSR_SEED   = 8'h5A;
    localparam int         LFSR_TAP_HI = 7;
    localparam int         LFSR_TAP_LO = 5;

    localparam int TG_IDX_W = 16;
    typedef logic [TG_IDX_W-1:0] tg_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_OFFER = 2'd2,
        ST_DONE  = 2'd3
    } dpm_state_t;

    // den must be non-zero; callers substitute 1 for a zero tile size.
    // Written as quotient plus remainder flag so num+den cannot overflow.
    function automatic logic [31:0] ceil_div(input logic [31:0] num,
                                             input logic [31:0] den);
        return (num / den) + (((num % den) != 32'd0) ? 32'd1 : 32'd0);
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/producer_dpm_if.sv
`default_nettype none
// ============================================================================
// Module      : producer_dpm_if
// Description : TileGroup FIFO write handshake between the producing DPM
//               (master) and the TileGroup FIFO (slave).
//               tg_valid / tg_ready : valid-ready handshake
//               tg_row / tg_col     : tile indices of the offered TileGroup
//               tg_last             : offered TileGroup closes the frame
// Revision    : 1.0 - initial release
// ============================================================================
interface producer_dpm_if #(
    parameter int WIDTH = 16
);
    logic             tg_valid;
    logic             tg_ready;
    logic [WIDTH-1:0] tg_row;
    logic [WIDTH-1:0] tg_col;
    logic             tg_last;

    modport master (
        output tg_valid,
        output tg_row,
        output tg_col,
        output tg_last,
        input  tg_ready
    );

    modport slave (
        input  tg_valid,
        input  tg_row,
        input  tg_col,
        input  tg_last,
        output tg_ready
    );
endinterface
`default_nettype wire

// File: rtl/dpm_jitter_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : dpm_jitter_lfsr
// Description : 8-bit LFSR that steps when advance=1, with clamped signed
//               jitter derived from it: lfsr[3:0]-lfsr[7:4] limited to
//               +/-JITTER. Jitter is given both for the current state and
//               for the state after the next step, so a caller can load a
//               wait value on the same edge that advances the LFSR.
// Ports       : clk, rst_n (async active-low), advance,
//               jitter_cur, jitter_next (signed 8-bit)
// Revision    : 1.0 - initial release
// ============================================================================
module dpm_jitter_lfsr
    import dpm_pkg::*;
#(
    parameter int JITTER = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              advance,
    output logic signed [7:0]      jitter_cur,
    output logic signed [7:0]      jitter_next
);

    // The raw difference spans -15..15, so larger limits never bind.
    localparam int c_jlim = (JITTER > 15) ? 15 : ((JITTER < 0) ? 0 : JITTER);
    localparam logic signed [7:0] c_jpos = 8'(c_jlim);
    localparam logic signed [7:0] c_jneg = -c_jpos;

    logic [7:0] r_lfsr;

    function automatic logic signed [7:0] clamp_jit(input logic [7:0] s);
        logic signed [7:0] d;
        d = $signed({4'b0000, s[3:0]}) - $signed({4'b0000, s[7:4]});
        if (d > c_jpos) return c_jpos;
        if (d < c_jneg) return c_jneg;
        return d;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (advance) begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign jitter_cur  = clamp_jit(r_lfsr);
    assign jitter_next = clamp_jit(lfsr_step(r_lfsr));

endmodule
`default_nettype wire

// File: rtl/producer_dpm.sv
`default_nettype none
// ============================================================================
// Module      : producer_dpm
// Description : Timing model of the producing DPM. Emits TileGroup tokens in
//               raster order into the TileGroup FIFO with a programmable
//               period plus bounded LFSR jitter, honours back-pressure,
//               counts accepted tokens and stall cycles, flags end of frame.
// Ports       : clk, rst_n (async active-low)
//               start                     - begin a frame (sampled in IDLE)
//               tile_rows / tile_columns  - tile size in pixels, 0 acts as 1
//               tg (producer_dpm_if.master) - TileGroup handshake
//               produced_count / stall_cycles - free-running statistics
//               busy / done               - frame in progress / end pulse
// Revision    : 1.0 - initial release
// ============================================================================
module producer_dpm
    import dpm_pkg::*;
#(
    parameter int FRAME_ROWS  = 1080,
    parameter int FRAME_COLS  = 1920,
    parameter int BASE_PERIOD = 120,
    parameter int JITTER      = 4,
    parameter int WIDTH       = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic [WIDTH-1:0]  tile_rows,
    input  wire logic [WIDTH-1:0]  tile_columns,
    producer_dpm_if.master         tg,
    output logic [31:0]            produced_count,
    output logic [31:0]            stall_cycles,
    output logic                   busy,
    output logic                   done
);

    dpm_state_t        r_state;
    logic [WIDTH-1:0]  r_row;
    logic [WIDTH-1:0]  r_col;
    logic [WIDTH-1:0]  r_nr;
    logic [WIDTH-1:0]  r_nc;
    logic [31:0]       r_period;
    logic [31:0]       r_timer;
    logic [31:0]       r_produced;
    logic [31:0]       r_stall;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;

    logic [WIDTH-1:0]  w_tr;
    logic [WIDTH-1:0]  w_tc;
    logic [WIDTH-1:0]  w_nr;
    logic [WIDTH-1:0]  w_nc;
    logic [31:0]       w_quot;
    logic [31:0]       w_p_calc;
    logic [31:0]       w_p_sel;
    logic signed [7:0] w_jit_cur;
    logic signed [7:0] w_jit_next;
    logic signed [7:0] w_jit_sel;
    logic signed [32:0] w_wait_s;
    logic [31:0]       w_wait;
    logic              w_hs;
    logic              w_last;

    // Frame geometry, only consumed on the IDLE->WAIT edge.
    assign w_tr     = (tile_rows    == '0) ? WIDTH'(1) : tile_rows;
    assign w_tc     = (tile_columns == '0) ? WIDTH'(1) : tile_columns;
    assign w_nr     = WIDTH'(ceil_div(32'(FRAME_ROWS), 32'(w_tr)));
    assign w_nc     = WIDTH'(ceil_div(32'(FRAME_COLS), 32'(w_tc)));
    assign w_quot   = 32'(BASE_PERIOD) / 32'(w_nc);
    assign w_p_calc = (w_quot == 32'd0) ? 32'd1 : w_quot;

    assign w_hs = (r_state == ST_OFFER) && tg.tg_ready;

    // At frame start the wait uses the freshly computed period and the
    // current LFSR; on a handshake the LFSR steps on the same edge, so the
    // reload must use the jitter of the post-step value.
    assign w_p_sel   = (r_state == ST_IDLE) ? w_p_calc  : r_period;
    assign w_jit_sel = (r_state == ST_IDLE) ? w_jit_cur : w_jit_next;
    assign w_wait_s  = $signed({1'b0, w_p_sel})
                     + $signed({{25{w_jit_sel[7]}}, w_jit_sel});
    assign w_wait    = (w_wait_s < 33'sd1) ? 32'd1 : w_wait_s[31:0];

    assign w_last = (r_row == r_nr - WIDTH'(1)) && (r_col == r_nc - WIDTH'(1));

    dpm_jitter_lfsr #(
        .JITTER      (JITTER)
    ) u_jitter (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance     (w_hs),
        .jitter_cur  (w_jit_cur),
        .jitter_next (w_jit_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_nr       <= '0;
            r_nc       <= '0;
            r_period   <= '0;
            r_timer    <= '0;
            r_produced <= '0;
            r_stall    <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_nr     <= w_nr;
                        r_nc     <= w_nc;
                        r_period <= w_p_calc;
                        r_row    <= '0;
                        r_col    <= '0;
                        r_timer  <= w_wait;
                        r_busy   <= 1'b1;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_timer <= r_timer - 32'd1;
                    if (r_timer <= 32'd1) begin
                        r_valid <= 1'b1;
                        r_state <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (tg.tg_ready) begin
                        r_produced <= r_produced + 32'd1;
                        r_valid    <= 1'b0;
                        if (r_col == r_nc - WIDTH'(1)) begin
                            r_col <= '0;
                            r_row <= r_row + WIDTH'(1);
                        end else begin
                            r_col <= r_col + WIDTH'(1);
                        end
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_timer <= w_wait;
                            r_state <= ST_WAIT;
                        end
                    end else begin
                        r_stall <= r_stall + 32'd1;
                    end
                end
                ST_DONE: begin
                    // start is deliberately not looked at here
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tg.tg_valid     = r_valid;
    assign tg.tg_row       = r_row;
    assign tg.tg_col       = r_col;
    assign tg.tg_last      = w_last;
    assign produced_count  = r_produced;
    assign stall_cycles    = r_stall;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_producer_dpm.sv
`default_nettype none
// ============================================================================
// Module      : tb_producer_dpm
// Description : Directed self-checking bench for producer_dpm. Four DUT
//               instances cover the parameter sets of interest:
//               0: 64x64 frame, BASE_PERIOD 40, no jitter
//               1: 64x64 frame, BASE_PERIOD 40, JITTER 4
//               2: 4x4 frame,   BASE_PERIOD 8,  no jitter
//               3: 64x64 frame, BASE_PERIOD 2,  no jitter (period clamps)
//               The gap measured per TileGroup is the number of clock edges
//               from the start/handshake edge to the edge that raises
//               tg_valid, which equals the wait value W.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_producer_dpm;
    import dpm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic [15:0] t_rows;
    logic [15:0] t_cols;
    logic        st  [4];
    logic        vld [4];
    logic        lst [4];
    logic        bsy [4];
    logic        dn  [4];
    tg_idx_t     rw  [4];
    tg_idx_t     cl  [4];
    logic [31:0] prod [4];
    logic [31:0] stl  [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    producer_dpm_if #(.WIDTH(16)) if_a ();
    producer_dpm_if #(.WIDTH(16)) if_b ();
    producer_dpm_if #(.WIDTH(16)) if_c ();
    producer_dpm_if #(.WIDTH(16)) if_d ();

    assign if_a.tg_ready = rdy;
    assign if_b.tg_ready = rdy;
    assign if_c.tg_ready = rdy;
    assign if_d.tg_ready = rdy;

    assign vld[0] = if_a.tg_valid; assign lst[0] = if_a.tg_last;
    assign rw[0]  = if_a.tg_row;   assign cl[0]  = if_a.tg_col;
    assign vld[1] = if_b.tg_valid; assign lst[1] = if_b.tg_last;
    assign rw[1]  = if_b.tg_row;   assign cl[1]  = if_b.tg_col;
    assign vld[2] = if_c.tg_valid; assign lst[2] = if_c.tg_last;
    assign rw[2]  = if_c.tg_row;   assign cl[2]  = if_c.tg_col;
    assign vld[3] = if_d.tg_valid; assign lst[3] = if_d.tg_last;
    assign rw[3]  = if_d.tg_row;   assign cl[3]  = if_d.tg_col;

    producer_dpm #(.FRAME_ROWS(64), .FRAME_COLS(64), .BASE_PERIOD(40), .JITTER(0), .WIDTH(16)) u_a (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .tile_rows(t_rows), .tile_columns(t_cols),
        .tg(if_a), .produced_count(prod[0]), .stall_cycles(stl[0]), .busy(bsy[0]), .done(dn[0]));
    producer_dpm #(.FRAME_ROWS(64), .FRAME_COLS(64), .BASE_PERIOD(40), .JITTER(4), .WIDTH(16)) u_b (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .tile_rows(t_rows), .tile_columns(t_cols),
        .tg(if_b), .produced_count(prod[1]), .stall_cycles(stl[1]), .busy(bsy[1]), .done(dn[1]));
    producer_dpm #(.FRAME_ROWS(4), .FRAME_COLS(4), .BASE_PERIOD(8), .JITTER(0), .WIDTH(16)) u_c (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .tile_rows(t_rows), .tile_columns(t_cols),
        .tg(if_c), .produced_count(prod[2]), .stall_cycles(stl[2]), .busy(bsy[2]), .done(dn[2]));
    producer_dpm #(.FRAME_ROWS(64), .FRAME_COLS(64), .BASE_PERIOD(2), .JITTER(0), .WIDTH(16)) u_d (
        .clk(clk), .rst_n(rst_n), .start(st[3]), .tile_rows(t_rows), .tile_columns(t_cols),
        .tg(if_d), .produced_count(prod[3]), .stall_cycles(stl[3]), .busy(bsy[3]), .done(dn[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int inst);
        st[inst] = 1'b1;
        tick();
        st[inst] = 1'b0;
    endtask

    // Counts edges until tg_valid rises (bounded), then checks the offer.
    task automatic wait_valid(input int inst, input int gap, input int er,
                              input int ec, input bit el);
        int n = 0;
        while (!vld[inst] && n < 300) begin
            tick();
            n++;
        end
        chk($sformatf("gap[%0d](%0d,%0d)", inst, er, ec), n, gap);
        chk($sformatf("row[%0d](%0d,%0d)", inst, er, ec), 32'(rw[inst]), er);
        chk($sformatf("col[%0d](%0d,%0d)", inst, er, ec), 32'(cl[inst]), ec);
        chk($sformatf("last[%0d](%0d,%0d)", inst, er, ec), 32'(lst[inst]), 32'(el));
    endtask

    // Offer followed by a handshake on the next edge (tg_ready held 1).
    task automatic tg_step(input int inst, input int gap, input int er,
                           input int ec, input bit el);
        wait_valid(inst, gap, er, ec, el);
        tick();
        chk($sformatf("drop[%0d](%0d,%0d)", inst, er, ec), 32'(vld[inst]), 0);
    endtask

    initial begin
        logic [7:0] m;
        int         hi, lo, j, w, n;

        rst_n  = 1'b0;
        rdy    = 1'b1;
        t_rows = 16'd16;
        t_cols = 16'd16;
        for (int i = 0; i < 4; i++) st[i] = 1'b0;
        #12;
        // ---- reset state ----
        chk("rst_valid", 32'(vld[0]), 0);
        chk("rst_busy",  32'(bsy[0]), 0);
        chk("rst_done",  32'(dn[0]),  0);
        chk("rst_last",  32'(lst[0]), 0);
        chk("rst_prod",  prod[0], 0);
        chk("rst_stall", stl[0],  0);
        rst_n = 1'b1;
        tick();

        // ---- frame 1: 4x4 tiles, W=10, ready always high ----
        pulse_start(0);
        chk("busy_run", 32'(bsy[0]), 1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                tg_step(0, 10, r, c, (r == 3) && (c == 3));
        chk("done_pulse", 32'(dn[0]),  1);
        chk("done_busy",  32'(bsy[0]), 1);
        tick();
        chk("done_clear", 32'(dn[0]),  0);
        chk("idle_busy",  32'(bsy[0]), 0);
        chk("prod_f1",    prod[0], 16);
        chk("stall_f1",   stl[0],  0);

        // ---- frame 2: 7-cycle stall on the third offer, stray starts ----
        pulse_start(0);
        tg_step(0, 10, 0, 0, 1'b0);
        tg_step(0, 10, 0, 1, 1'b0);
        rdy = 1'b0;
        wait_valid(0, 10, 0, 2, 1'b0);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk($sformatf("hold_valid%0d", k), 32'(vld[0]), 1);
            chk($sformatf("hold_row%0d", k),   32'(rw[0]),  0);
            chk($sformatf("hold_col%0d", k),   32'(cl[0]),  2);
        end
        rdy = 1'b1;
        tick();
        chk("stall_7", stl[0], 7);
        tg_step(0, 10, 0, 3, 1'b0);
        pulse_start(0);                 // start while busy: ignored
        tg_step(0, 9, 1, 0, 1'b0);
        for (int r = 1; r < 4; r++)
            for (int c = (r == 1) ? 1 : 0; c < 4; c++)
                tg_step(0, 10, r, c, (r == 3) && (c == 3));
        chk("done_f2", 32'(dn[0]), 1);
        pulse_start(0);                 // start in the done cycle: ignored
        chk("no_restart_busy", 32'(bsy[0]), 0);
        tick();
        chk("no_restart_busy2",  32'(bsy[0]), 0);
        chk("no_restart_valid",  32'(vld[0]), 0);
        chk("prod_f2", prod[0], 32);
        chk("stall_f2", stl[0], 7);

        // ---- jitter: reference LFSR seeded 8'h5A, stepped per handshake ----
        m = 8'h5A;
        pulse_start(1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                lo = int'(m[3:0]);
                hi = int'(m[7:4]);
                j  = lo - hi;
                if (j > 4)  j = 4;
                if (j < -4) j = -4;
                w  = 10 + j;
                tg_step(1, w, r, c, (r == 3) && (c == 3));
                chk($sformatf("jit_range(%0d,%0d)", r, c), 32'((w >= 6) && (w <= 14)), 1);
                m = {m[6:0], m[7] ^ m[5]};
            end
        chk("prod_jit", prod[1], 16);

        // ---- zero tile size acts as 1: 4x4 grid, P=8/4=2 ----
        t_rows = 16'd0;
        t_cols = 16'd0;
        pulse_start(2);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                tg_step(2, 2, r, c, (r == 3) && (c == 3));
        chk("zero_done", 32'(dn[2]), 1);
        tick();
        // ---- whole-frame tile: single TileGroup, P=8 ----
        t_rows = 16'd4;
        t_cols = 16'd4;
        pulse_start(2);
        tg_step(2, 8, 0, 0, 1'b1);
        chk("single_done", 32'(dn[2]), 1);
        tick();
        chk("single_prod", prod[2], 17);

        // ---- period clamp: 2/4=0 -> P=1, one TileGroup every two cycles ----
        t_rows = 16'd16;
        t_cols = 16'd16;
        pulse_start(3);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                tg_step(3, 1, r, c, (r == 3) && (c == 3));
        chk("clamp_prod", prod[3], 16);
        tick();

        // ---- asynchronous reset while offering ----
        rdy = 1'b0;
        pulse_start(0);
        wait_valid(0, 10, 0, 0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(vld[0]), 0);
        chk("abort_busy",  32'(bsy[0]), 0);
        chk("abort_done",  32'(dn[0]),  0);
        chk("abort_prod",  prod[0], 0);
        chk("abort_stall", stl[0],  0);
        n = 32'(rw[0]) + 32'(cl[0]);
        chk("abort_idx", n, 0);
        #2;
        rst_n = 1'b1;
        rdy   = 1'b1;
        tick();
        chk("post_abort_valid", 32'(vld[0]), 0);
        chk("post_abort_done",  32'(dn[0]),  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
